exp_mul_job_scheduler: RTL and testbench

- Shares one exponent_multiplier datapath between two independent requesters (e.g. AXI slave path and a local test sequencer).
- Arbitrates round-robin and sequences the core's load/start pulses.
- Waits for completion with a timeout guard, then returns the 30-bit result to the granted requester over a valid/ready response handshake.
- Sits between the requesters and the core instance; the core itself is instantiated by the parent.

---
 rtl/exp_mul_pkg.sv | 28 ++
 rtl/exp_mul_job_scheduler_rr_arbiter2.sv | 19 +
 rtl/exp_mul_job_scheduler.sv | 158 +++++++++++++++
 tb/tb_exp_mul_job_scheduler.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_mul_pkg.sv
// Shared types for the exponent/multiplier job scheduler and its arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package exp_mul_pkg;

    localparam int OP_W  = 4;
    localparam int RES_W = 30;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        SEL_MUL = 1'b0,
        SEL_EXP = 1'b1
    } sel_t;

    typedef struct packed {
        sel_t            select;
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } job_t;

endpackage

// File: rtl/exp_mul_job_scheduler_rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to ptr.
// Latency: combinational.
// Backpressure: none; the caller masks req when it cannot accept.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant[ptr] = 1'b1;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/exp_mul_job_scheduler.sv
// Shares one exponent_multiplier core between two requesters with round-robin grant and timeout.
// Latency: accept -> core_load +1, core_start +2, rsp_valid >= +5 (done is ignored in first WAIT cycle).
// Backpressure: one job in flight; req_ready stays low until the response handshake returns to IDLE.
module exp_mul_job_scheduler
    import exp_mul_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESETN,
    input  logic             req_valid_0,
    input  logic             req_valid_1,
    output logic             req_ready_0,
    output logic             req_ready_1,
    input  logic             req_select_0,
    input  logic             req_select_1,
    input  logic [OP_W-1:0]  req_a_0,
    input  logic [OP_W-1:0]  req_a_1,
    input  logic [OP_W-1:0]  req_b_0,
    input  logic [OP_W-1:0]  req_b_1,
    output logic             rsp_valid_0,
    output logic             rsp_valid_1,
    input  logic             rsp_ready_0,
    input  logic             rsp_ready_1,
    output logic [RES_W-1:0] rsp_data,
    output logic             rsp_timeout,
    output logic             core_load,
    output logic             core_start,
    output logic             core_select,
    output logic [OP_W-1:0]  core_a,
    output logic [OP_W-1:0]  core_b,
    input  logic             core_done,
    input  logic [RES_W-1:0] core_p,
    output logic             busy,
    output logic             owner,
    output logic [CNT_W-1:0] jobs_done_0,
    output logic [CNT_W-1:0] jobs_done_1
);

    localparam int                WCNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic              rr_ptr;
    job_t              job;
    job_t              req_job_0;
    job_t              req_job_1;
    logic [WCNT_W-1:0] wait_cnt;
    logic [1:0]        arb_req;
    logic [1:0]        arb_gnt;
    logic              done_hit;
    logic              timeout_hit;
    logic              rsp_hs;

    assign req_job_0 = '{select: sel_t'(req_select_0), a: req_a_0, b: req_b_0};
    assign req_job_1 = '{select: sel_t'(req_select_1), a: req_a_1, b: req_b_1};

    // Requests are only visible to the arbiter while idle and out of reset.
    assign arb_req = {req_valid_1, req_valid_0} & {2{(state == IDLE) && S_AXI_ARESETN}};

    rr_arbiter2 u_arb (
        .req   (arb_req),
        .ptr   (rr_ptr),
        .grant (arb_gnt)
    );

    assign core_select = job.select;
    assign core_a      = job.a;
    assign core_b      = job.b;

    always_comb begin
        state_nxt   = state;
        req_ready_0 = arb_gnt[0];
        req_ready_1 = arb_gnt[1];
        core_load   = 1'b0;
        core_start  = 1'b0;
        rsp_valid_0 = 1'b0;
        rsp_valid_1 = 1'b0;
        busy        = (state != IDLE);
        done_hit    = 1'b0;
        timeout_hit = 1'b0;
        rsp_hs      = 1'b0;
        case (state)
            IDLE: begin
                if (|arb_gnt) state_nxt = LOAD;
            end
            LOAD: begin
                core_load = 1'b1;
                state_nxt = START;
            end
            START: begin
                core_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                // A done still high from the previous job is visible in the first cycle only.
                done_hit    = core_done && (wait_cnt != '0);
                timeout_hit = (wait_cnt == WAIT_LAST);
                if (done_hit || timeout_hit) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid_0 = ~owner;
                rsp_valid_1 = owner;
                rsp_hs      = owner ? rsp_ready_1 : rsp_ready_0;
                if (rsp_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            owner       <= 1'b0;
            job         <= '0;
            wait_cnt    <= '0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            jobs_done_0 <= '0;
            jobs_done_1 <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (|arb_gnt) begin
                        owner <= arb_gnt[1];
                        job   <= arb_gnt[1] ? req_job_1 : req_job_0;
                    end
                end
                START: wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (done_hit) begin
                        rsp_data    <= core_p;
                        rsp_timeout <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        rr_ptr <= ~owner;
                        if (!rsp_timeout) begin
                            if (owner) jobs_done_1 <= jobs_done_1 + 1'b1;
                            else       jobs_done_0 <= jobs_done_0 + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_mul_job_scheduler.sv
// Randomized scoreboard bench for exp_mul_job_scheduler with a behavioural core model.
module tb_exp_mul_job_scheduler;
    import exp_mul_pkg::*;

    localparam int TO = 8;
    localparam int CW = 3;

    logic             S_AXI_ACLK = 1'b0;
    logic             S_AXI_ARESETN = 1'b0;
    logic             req_valid_0 = 1'b0, req_valid_1 = 1'b0;
    logic             req_ready_0, req_ready_1;
    logic             req_select_0 = 1'b0, req_select_1 = 1'b0;
    logic [OP_W-1:0]  req_a_0 = '0, req_a_1 = '0, req_b_0 = '0, req_b_1 = '0;
    logic             rsp_valid_0, rsp_valid_1;
    logic             rsp_ready_0 = 1'b0, rsp_ready_1 = 1'b0;
    logic [RES_W-1:0] rsp_data;
    logic             rsp_timeout;
    logic             core_load, core_start, core_select;
    logic [OP_W-1:0]  core_a, core_b;
    logic             core_done = 1'b0;
    logic [RES_W-1:0] core_p = '0;
    logic             busy, owner;
    logic [CW-1:0]    jobs_done_0, jobs_done_1;

    exp_mul_job_scheduler #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_select_0(req_select_0), .req_select_1(req_select_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1), .req_b_0(req_b_0), .req_b_1(req_b_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
        .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .core_load(core_load), .core_start(core_start), .core_select(core_select),
        .core_a(core_a), .core_b(core_b), .core_done(core_done), .core_p(core_p),
        .busy(busy), .owner(owner), .jobs_done_0(jobs_done_0), .jobs_done_1(jobs_done_1)
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result of the core operation from plain arithmetic: A*B or A**B, kept to 30 bits.
    function automatic logic [RES_W-1:0] ref_result(input logic sel, input logic [OP_W-1:0] a,
                                                   input logic [OP_W-1:0] b);
        logic [63:0] r;
        if (!sel) begin
            r = 64'(a) * 64'(b);
        end else begin
            r = 64'd1;
            for (int i = 0; i < int'(b); i++) r = r * 64'(a);
        end
        return r[RES_W-1:0];
    endfunction

    // Per-job core behaviour: never finish, keep previous done high into WAIT, latency to done.
    typedef struct packed {
        logic       nodone;
        logic       stale;
        logic [3:0] lat;
    } cfg_t;

    cfg_t        cfg_q[$];
    cfg_t        dir_cfg = '{nodone: 1'b0, stale: 1'b0, lat: 4'd4};
    cfg_t        cur_cfg;
    logic        cfg_random = 1'b0;
    logic [30:0] exp_q0[$];
    logic [30:0] exp_q1[$];

    logic [3:0]       cm_cnt  = '0;
    logic             cm_pend = 1'b0;
    logic [RES_W-1:0] cm_p    = '0;

    always @(posedge S_AXI_ACLK) begin
        if (core_start) begin
            cur_cfg = (cfg_q.size() > 0) ? cfg_q.pop_front() : dir_cfg;
            cm_cnt  <= cur_cfg.lat;
            cm_p    <= ref_result(core_select, core_a, core_b);
            cm_pend <= !cur_cfg.nodone;
            if (!cur_cfg.stale || cur_cfg.nodone) core_done <= 1'b0;
        end else if (cm_pend) begin
            if (cm_cnt <= 4'd1) begin
                core_done <= 1'b1;
                core_p    <= cm_p;
                cm_pend   <= 1'b0;
            end else begin
                core_done <= 1'b0;
                cm_cnt    <= cm_cnt - 4'd1;
            end
        end
    end

    logic hold_low = 1'b0;
    initial forever begin
        @(posedge S_AXI_ACLK);
        #1;
        rsp_ready_0 = !hold_low && ($urandom_range(3) != 0);
        rsp_ready_1 = ($urandom_range(3) != 0);
    end

    // Monitor / scoreboard
    int          cyc = 0;
    int          acc_cyc = -100;
    logic        mptr = 1'b0;
    logic        mbusy = 1'b0;
    logic        exp_owner = 1'b0;
    logic [CW-1:0] mdone0 = '0, mdone1 = '0;
    logic        hold0 = 1'b0, hold1 = 1'b0;
    logic [30:0] prev_rsp = '0;
    logic [30:0] e;
    logic [1:0]  eg;
    logic        owner_log[$];

    always @(negedge S_AXI_ACLK) begin
        cyc++;
        if (!S_AXI_ARESETN) begin
            mptr = 1'b0; mbusy = 1'b0; mdone0 = '0; mdone1 = '0;
            hold0 = 1'b0; hold1 = 1'b0; acc_cyc = -100;
        end else begin
            eg = 2'b00;
            if (!mbusy) begin
                if (req_valid_0 && req_valid_1) eg[mptr] = 1'b1;
                else                            eg = {req_valid_1, req_valid_0};
            end
            check("req_ready", 64'({req_ready_1, req_ready_0}), 64'(eg));
            check("busy", 64'(busy), 64'(mbusy));
            check("core_load", 64'(core_load), 64'(cyc == acc_cyc + 1));
            check("core_start", 64'(core_start), 64'(cyc == acc_cyc + 2));
            if (cyc == acc_cyc + 1) check("owner", 64'(owner), 64'(exp_owner));
            check("jobs_done_0", 64'(jobs_done_0), 64'(mdone0));
            check("jobs_done_1", 64'(jobs_done_1), 64'(mdone1));
            if (!mbusy) check("rsp_idle", 64'({rsp_valid_1, rsp_valid_0}), 64'(0));
            if (rsp_valid_0 || rsp_valid_1)
                check("rsp_route", 64'({rsp_valid_1, rsp_valid_0}), 64'(exp_owner ? 2'b10 : 2'b01));
            if (hold0) check("hold_valid_0", 64'(rsp_valid_0), 64'(1));
            if (hold1) check("hold_valid_1", 64'(rsp_valid_1), 64'(1));
            if (hold0 || hold1) check("hold_stable", 64'({rsp_timeout, rsp_data}), 64'(prev_rsp));
            if (rsp_valid_0 && rsp_ready_0) begin
                if (exp_q0.size() == 0) begin
                    check("rsp0_unexpected", 64'(exp_q0.size()), 64'(1));
                end else begin
                    e = exp_q0.pop_front();
                    check("rsp0_result", 64'({rsp_timeout, rsp_data}), 64'(e));
                    if (!e[30]) mdone0++;
                end
                mptr = 1'b1; mbusy = 1'b0;
            end
            if (rsp_valid_1 && rsp_ready_1) begin
                if (exp_q1.size() == 0) begin
                    check("rsp1_unexpected", 64'(exp_q1.size()), 64'(1));
                end else begin
                    e = exp_q1.pop_front();
                    check("rsp1_result", 64'({rsp_timeout, rsp_data}), 64'(e));
                    if (!e[30]) mdone1++;
                end
                mptr = 1'b0; mbusy = 1'b0;
            end
            if ((req_valid_0 && req_ready_0) || (req_valid_1 && req_ready_1)) begin
                acc_cyc   = cyc;
                exp_owner = req_ready_1;
                owner_log.push_back(req_ready_1);
                mbusy     = 1'b1;
            end
            hold0    = rsp_valid_0 && !rsp_ready_0;
            hold1    = rsp_valid_1 && !rsp_ready_1;
            prev_rsp = {rsp_timeout, rsp_data};
        end
    end

    task automatic drive(input int k, input logic v, input logic s, input logic [3:0] a, input logic [3:0] b);
        if (k == 0) begin
            req_valid_0 = v; req_select_0 = s; req_a_0 = a; req_b_0 = b;
        end else begin
            req_valid_1 = v; req_select_1 = s; req_a_1 = a; req_b_1 = b;
        end
    endtask

    // Present a job until accepted and push its expected response.
    task automatic send(input int k, input logic s, input logic [3:0] a, input logic [3:0] b);
        int   t  = 0;
        logic ok = 1'b0;
        cfg_t c;
        @(posedge S_AXI_ACLK);
        #1;
        drive(k, 1'b1, s, a, b);
        while (!ok && t < 3000) begin
            @(negedge S_AXI_ACLK);
            ok = (k == 0) ? req_ready_0 : req_ready_1;
            t++;
        end
        if (!ok) check("accept_wait", 64'(ok), 64'(1));
        @(posedge S_AXI_ACLK);
        if (ok) begin
            c = dir_cfg;
            if (cfg_random) begin
                c.nodone = ($urandom_range(7) == 0);
                c.stale  = 1'($urandom_range(1));
                c.lat    = 4'($urandom_range(7, 1));
            end
            cfg_q.push_back(c);
            if (k == 0) exp_q0.push_back({c.nodone, c.nodone ? '0 : ref_result(s, a, b)});
            else        exp_q1.push_back({c.nodone, c.nodone ? '0 : ref_result(s, a, b)});
        end
        #1;
        drive(k, 1'b0, 1'($urandom_range(1)), 4'($urandom_range(15)), 4'($urandom_range(15)));
    endtask

    task automatic cycles_to_rsp(input int k, output int n);
        n = 0;
        do begin
            @(negedge S_AXI_ACLK);
            n++;
        end while (!((k == 0) ? rsp_valid_0 : rsp_valid_1) && n < 200);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || mbusy) && t < 3000) begin
            @(negedge S_AXI_ACLK);
            t++;
        end
        check("drain", 64'(exp_q0.size() + exp_q1.size() + int'(mbusy)), 64'(0));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, 64'({rsp_valid_0, rsp_valid_1, req_ready_0, req_ready_1, core_load,
                                    core_start, core_select, core_a, core_b, busy, owner}), 64'(0));
        check({name, "_data"}, 64'({rsp_timeout, rsp_data, jobs_done_0, jobs_done_1}), 64'(0));
    endtask

    task automatic do_reset();
        @(posedge S_AXI_ACLK);
        #1;
        S_AXI_ARESETN = 1'b0;
        repeat (2) @(posedge S_AXI_ACLK);
        @(negedge S_AXI_ACLK);
        check_all_zero("reset");
        @(posedge S_AXI_ACLK);
        #1;
        S_AXI_ARESETN = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   t;
        logic f_done;
        repeat (3) @(posedge S_AXI_ACLK);
        @(negedge S_AXI_ACLK);
        check_all_zero("reset_initial");
        @(posedge S_AXI_ACLK);
        #1;
        S_AXI_ARESETN = 1'b1;

        // Single multiply on requester 0.
        dir_cfg = '{nodone: 1'b0, stale: 1'b0, lat: 4'd4};
        send(0, 1'b0, 4'd3, 4'd5);
        cycles_to_rsp(0, n);
        check("single_latency", 64'(n), 64'(8));
        drain();
        check("single_jobs_done_0", 64'(jobs_done_0), 64'(1));

        // Done still high from the previous job must not complete the next one.
        dir_cfg = '{nodone: 1'b0, stale: 1'b1, lat: 4'd1};
        send(0, 1'b0, 4'd2, 4'd3);
        cycles_to_rsp(0, n);
        check("stale_latency", 64'(n), 64'(5));
        drain();

        // Simultaneous requests after reset: requester 0 first, then 1.
        do_reset();
        dir_cfg = '{nodone: 1'b0, stale: 1'b0, lat: 4'd3};
        owner_log.delete();
        fork
            send(0, 1'b1, 4'd2, 4'd10);
            send(1, 1'b0, 4'd7, 4'd9);
        join
        drain();
        check("rr_grants", 64'(owner_log.size()), 64'(2));
        if (owner_log.size() == 2) check("rr_order", 64'({owner_log[0], owner_log[1]}), 64'(2'b01));

        // Core never finishes: timeout after TO WAIT cycles.
        dir_cfg = '{nodone: 1'b1, stale: 1'b0, lat: 4'd1};
        send(1, 1'b0, 4'd4, 4'd4);
        cycles_to_rsp(1, n);
        check("timeout_latency", 64'(n), 64'(3 + TO));
        drain();

        // Done arriving on the last WAIT cycle beats the timeout.
        dir_cfg = '{nodone: 1'b0, stale: 1'b0, lat: 4'(TO - 1)};
        send(0, 1'b1, 4'd3, 4'd4);
        drain();

        // Response held off for 20 cycles while the other requester waits.
        dir_cfg = '{nodone: 1'b0, stale: 1'b0, lat: 4'd2};
        hold_low = 1'b1;
        send(0, 1'b0, 4'd9, 4'd9);
        f_done = 1'b0;
        fork
            begin
                send(1, 1'b0, 4'd2, 4'd3);
                f_done = 1'b1;
            end
        join_none
        cycles_to_rsp(0, n);
        repeat (20) begin
            @(negedge S_AXI_ACLK);
            check("hold_rsp_valid_0", 64'(rsp_valid_0), 64'(1));
            check("hold_req_ready_1", 64'(req_ready_1), 64'(0));
            check("hold_rsp_data", 64'(rsp_data), 64'(81));
        end
        hold_low = 1'b0;
        t = 0;
        while (!f_done && t < 3000) begin
            @(negedge S_AXI_ACLK);
            t++;
        end
        check("hold_second_accept", 64'(f_done), 64'(1));
        drain();

        // Reset in the middle of WAIT aborts the job silently.
        dir_cfg = '{nodone: 1'b0, stale: 1'b0, lat: 4'd7};
        send(1, 1'b1, 4'd5, 4'd6);
        t = 0;
        while (!core_start && t < 50) begin
            @(negedge S_AXI_ACLK);
            t++;
        end
        check("reset_test_start_seen", 64'(core_start), 64'(1));
        repeat (2) @(posedge S_AXI_ACLK);
        #1;
        S_AXI_ARESETN = 1'b0;
        @(posedge S_AXI_ACLK);
        @(negedge S_AXI_ACLK);
        check_all_zero("reset_mid_job");
        exp_q1.delete();
        @(posedge S_AXI_ACLK);
        #1;
        S_AXI_ARESETN = 1'b1;
        owner_log.delete();
        dir_cfg = '{nodone: 1'b0, stale: 1'b0, lat: 4'd2};
        fork
            send(1, 1'b0, 4'd4, 4'd4);
            send(0, 1'b1, 4'd3, 4'd3);
        join
        drain();
        check("post_reset_grants", 64'(owner_log.size()), 64'(2));
        if (owner_log.size() == 2) check("post_reset_order", 64'({owner_log[0], owner_log[1]}), 64'(2'b01));

        // Random traffic from both requesters with random core behaviour.
        cfg_random = 1'b1;
        fork
            for (int j = 0; j < 14; j++) begin
                repeat ($urandom_range(3)) @(posedge S_AXI_ACLK);
                send(0, 1'($urandom_range(1)), 4'($urandom_range(15)), 4'($urandom_range(15)));
            end
            for (int j = 0; j < 14; j++) begin
                repeat ($urandom_range(3)) @(posedge S_AXI_ACLK);
                send(1, 1'($urandom_range(1)), 4'($urandom_range(15)), 4'($urandom_range(15)));
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
